idma_lane_realign_buffer: RTL and testbench
===========================================

Name: idma_lane_realign_buffer

Overview:
- Parametrised successor to the transport layer's fixed buffer-plus-shifter datapath.
- One block holds one independent FIFO per byte lane with configurable depth, an input rotator, an output rotator, per-lane occupancy reporting and a synchronous flush.
- It sits between any read port (OBI, AXI, ...) and any write port, and realigns and coalesces misaligned byte streams.
- Non-power-of-two depths, flush on datapath poison and fill-level visibility are all supported.

Parameters:
- StrbWidth, 8, number of byte lanes; power of two, ≥2.
- Depth, 3, entries per lane FIFO; ≥2, any integer (3 is legal).
- ShiftWidth, $clog2(StrbWidth), width of the shift inputs (derived, not overridable).
- FillWidth, $clog2(Depth+1), width of each lane fill count (derived).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- flush_i  in  1  drop all buffered bytes.
- in_shift_i  in  ShiftWidth  right-rotate amount applied to the input.
- in_data_i  in  8*StrbWidth  input bytes.
- in_valid_i  in  StrbWidth  per-byte input valid.
- in_ready_o  out  StrbWidth  per-byte input ready.
- out_shift_i  in  ShiftWidth  right-rotate amount applied to the output.
- out_data_o  out  8*StrbWidth  output bytes.
- out_valid_o  out  StrbWidth  per-byte output valid.
- out_ready_i  in  StrbWidth  per-byte output ready.
- lane_fill_o  out  StrbWidth*FillWidth  per-buffer-lane occupancy; lane j at [j*FillWidth +: FillWidth].
- busy_o  out  1  any lane non-empty.

Behaviour:
- Input mapping: buffer lane j takes in_data_i byte (j+in_shift_i) mod StrbWidth, and that byte's valid.
  - in_ready_o[i] = not-full of buffer lane (i−in_shift_i) mod StrbWidth.
  - A byte is accepted only when its own valid and ready are both high. Lanes are independent; there is no all-lanes-together requirement.
- Output mapping:
  - out_data_o byte k = head of buffer lane (k+out_shift_i) mod StrbWidth.
  - out_valid_o[k] = that lane is non-empty.
  - The lane pops when out_valid_o[k] and out_ready_i[k] are both high.
- Latency: no fall-through. A byte written in cycle n is visible on the output in cycle n+1 at the earliest. Write-to-read latency is exactly 1 cycle on an empty lane.
- Full lane: ready is low even if it pops in the same cycle, so there is no combinational ready-through from out_ready_i.
- Simultaneous push and pop on a non-full, non-empty lane: the fill count is unchanged and both pointers advance.
- Pointers: per-lane read/write pointers wrap from Depth−1 to 0, which is explicit for non-power-of-two Depth. The fill counter ranges 0..Depth.
  - Full means fill==Depth.
  - Empty means fill==0.
- Flush:
  - In the flush_i cycle: in_ready_o=0 and out_valid_o=0; no push or pop takes effect.
  - Next cycle: all fills are 0 and all pointers are 0.
  - Flush dominates any concurrent handshake.
- Reset:
  - While rst_i is high: in_ready_o=0, out_valid_o=0, lane_fill_o=0, busy_o=0.
  - The first cycle after release: in_ready_o all ones.
  - Reset mid-transfer discards all data, identical to flush.
  - out_data_o is don't-care whenever its valid is low; storage is not reset.
- busy_o = OR over lanes of (fill≠0), taken from registered state.
- Shift inputs are sampled combinationally each cycle and may change per beat. The block does not check consistency with the data; that is the caller's duty.

Test Plan (StrbWidth=4, Depth=3):
- Aligned stream, both shifts 0:
  - Stimulus: in_data=0x44332211, all valid, out_ready=0xF.
  - Required: out_data=0x44332211 with out_valid=0xF exactly one cycle later; busy_o high 1 cycle.
  - Sustained 1 beat/cycle throughput.
- Misaligned realign, in_shift=1, out_shift=0:
  - Stimulus: beat 0x44332211 valid=0xE, then beat 0x88776655 valid=0x1.
  - Required: bytes written to buffer lanes 0..3 = 0x22,0x33,0x44,0x55; output word 0x55443322 with valid 0xF.
- Full / backpressure, out_ready=0:
  - Stimulus: push 4 full beats.
  - Required: after beat 3, lane_fill=3 on all lanes and in_ready_o=0x0; beat 4 is not accepted.
  - Then out_ready=0x1 for one cycle: only lane 0 pops and in_ready_o[0]=1 the next cycle.
- Simultaneous push/pop at fill=2, all lanes:
  - Required: fill stays 2, output order preserved across pointer wrap (Depth=3), sequence 0x..01→0x..02→0x..03 in order.
- Flush mid-stream:
  - Stimulus: fill=2, flush_i asserted together with valid input.
  - Required: that cycle in_ready_o=0, out_valid_o=0; next cycle lane_fill_o=0, busy_o=0, and the flushed data never appears.
- Synchronous reset mid-operation:
  - Stimulus: rst_i high for 1 cycle with fill=3.
  - Required: outputs match reset values during reset; afterwards in_ready_o=0xF and a fresh beat emerges unaltered after 1 cycle.

Source files
------------

// File: rtl/idma_lane_realign_buffer.sv
// Byte-lane realignment buffer: one small FIFO per byte lane between an input
// rotator and an output rotator, with per-lane fill reporting and flush.

module idma_lane_realign_fifo #(
    parameter int unsigned Depth     = 3,
    parameter int unsigned FillWidth = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 push_valid_i,
    input  logic [7:0]           push_data_i,
    output logic                 push_ready_o,
    output logic                 pop_valid_o,
    output logic [7:0]           pop_data_o,
    input  logic                 pop_ready_i,
    output logic [FillWidth-1:0] fill_o
);
    localparam int unsigned PtrWidth = $clog2(Depth);

    logic [7:0]           mem [Depth];
    logic [PtrWidth-1:0]  wptr_q, rptr_q;
    logic [FillWidth-1:0] fill_q;
    logic                 push, pop;

    // Ready depends only on registered fill, never on pop_ready_i
    assign push_ready_o = !rst_i && !flush_i && (fill_q != FillWidth'(Depth));
    assign pop_valid_o  = !rst_i && !flush_i && (fill_q != '0);
    assign push         = push_valid_i && push_ready_o;
    assign pop          = pop_valid_o && pop_ready_i;
    assign pop_data_o   = mem[rptr_q];
    assign fill_o       = rst_i ? '0 : fill_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            // Explicit wrap so non-power-of-two depths work
            if (push) wptr_q <= (wptr_q == PtrWidth'(Depth - 1)) ? '0 : wptr_q + 1'b1;
            if (pop)  rptr_q <= (rptr_q == PtrWidth'(Depth - 1)) ? '0 : rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr_q] <= push_data_i;
    end
endmodule

module idma_lane_realign_buffer #(
    parameter  int unsigned StrbWidth  = 8,
    parameter  int unsigned Depth      = 3,
    localparam int unsigned ShiftWidth = $clog2(StrbWidth),
    localparam int unsigned FillWidth  = $clog2(Depth + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic [ShiftWidth-1:0]          in_shift_i,
    input  logic [8*StrbWidth-1:0]         in_data_i,
    input  logic [StrbWidth-1:0]           in_valid_i,
    output logic [StrbWidth-1:0]           in_ready_o,
    input  logic [ShiftWidth-1:0]          out_shift_i,
    output logic [8*StrbWidth-1:0]         out_data_o,
    output logic [StrbWidth-1:0]           out_valid_o,
    input  logic [StrbWidth-1:0]           out_ready_i,
    output logic [StrbWidth*FillWidth-1:0] lane_fill_o,
    output logic                           busy_o
);
    logic [StrbWidth-1:0][7:0]           lane_wdata, lane_head;
    logic [StrbWidth-1:0]                lane_wvalid, lane_ready, lane_valid, lane_pop_ready;
    logic [StrbWidth-1:0][FillWidth-1:0] lane_fill;

    for (genvar j = 0; j < StrbWidth; j++) begin : g_lane
        // Modulo arithmetic falls out of the ShiftWidth truncation (StrbWidth is 2^n)
        logic [ShiftWidth-1:0] in_src, in_dst, out_src, out_dst;
        assign in_src = ShiftWidth'(j) + in_shift_i;
        assign in_dst = ShiftWidth'(j) - in_shift_i;
        assign out_src = ShiftWidth'(j) + out_shift_i;
        assign out_dst = ShiftWidth'(j) - out_shift_i;

        assign lane_wdata[j]     = in_data_i[8*in_src +: 8];
        assign lane_wvalid[j]    = in_valid_i[in_src];
        assign in_ready_o[j]     = lane_ready[in_dst];
        assign out_data_o[8*j +: 8] = lane_head[out_src];
        assign out_valid_o[j]    = lane_valid[out_src];
        assign lane_pop_ready[j] = out_ready_i[out_dst];
        assign lane_fill_o[j*FillWidth +: FillWidth] = lane_fill[j];

        idma_lane_realign_fifo #(
            .Depth     (Depth),
            .FillWidth (FillWidth)
        ) i_fifo (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .flush_i      (flush_i),
            .push_valid_i (lane_wvalid[j]),
            .push_data_i  (lane_wdata[j]),
            .push_ready_o (lane_ready[j]),
            .pop_valid_o  (lane_valid[j]),
            .pop_data_o   (lane_head[j]),
            .pop_ready_i  (lane_pop_ready[j]),
            .fill_o       (lane_fill[j])
        );
    end

    assign busy_o = |lane_fill_o;
endmodule

// File: tb/tb_idma_lane_realign_buffer.sv
// Directed bench for idma_lane_realign_buffer with StrbWidth=4, Depth=3.

module tb_idma_lane_realign_buffer;
    logic        clk = 1'b0;
    logic        rst_i, flush_i;
    logic [1:0]  in_shift_i, out_shift_i;
    logic [31:0] in_data_i, out_data_o;
    logic [3:0]  in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [7:0]  lane_fill_o;
    logic        busy_o;
    int          checks = 0;
    int          failures = 0;

    idma_lane_realign_buffer #(.StrbWidth(4), .Depth(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_shift_i  (in_shift_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_shift_i (out_shift_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .lane_fill_o (lane_fill_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1; flush_i = 0; in_shift_i = 0; out_shift_i = 0;
        in_data_i = 0; in_valid_i = 0; out_ready_i = 0;
        tick();
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_fill", lane_fill_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_i = 0;
        tick();
        chk("post_rst_ready", in_ready_o, 4'hF);

        // Aligned single beat: one cycle latency, busy for one cycle
        in_data_i = 32'h44332211; in_valid_i = 4'hF; out_ready_i = 4'hF;
        #1 chk("al_no_fallthru", out_valid_o, 0);
        tick();
        in_valid_i = 0;
        #1 chk("al_data", out_data_o, 32'h44332211);
        chk("al_valid", out_valid_o, 4'hF);
        chk("al_busy", busy_o, 1);
        tick();
        chk("al_busy_clr", busy_o, 0);

        // Sustained one beat per cycle
        in_data_i = 32'h01010101; in_valid_i = 4'hF;
        tick();
        in_data_i = 32'h02020202;
        #1 chk("tp_out1", out_data_o, 32'h01010101);
        chk("tp_ready1", in_ready_o, 4'hF);
        tick();
        in_data_i = 32'h03030303;
        #1 chk("tp_out2", out_data_o, 32'h02020202);
        tick();
        in_valid_i = 0;
        #1 chk("tp_out3", out_data_o, 32'h03030303);
        chk("tp_valid3", out_valid_o, 4'hF);
        tick();
        chk("tp_idle", busy_o, 0);

        // Misaligned realign, in_shift=1
        out_ready_i = 0; in_shift_i = 1;
        in_data_i = 32'h44332211; in_valid_i = 4'hE;
        tick();
        in_data_i = 32'h88776655; in_valid_i = 4'h1;
        #1 chk("ma_part_valid", out_valid_o, 4'h7);
        chk("ma_part_fill", lane_fill_o, 8'h15);
        tick();
        in_valid_i = 0; in_shift_i = 0;
        #1 chk("ma_data", out_data_o, 32'h55443322);
        chk("ma_valid", out_valid_o, 4'hF);
        chk("ma_fill", lane_fill_o, 8'h55);
        out_shift_i = 1;
        #1 chk("ma_outshift", out_data_o, 32'h22554433);
        out_shift_i = 0; out_ready_i = 4'hF;
        tick();
        chk("ma_drained", busy_o, 0);

        // Fill to full under backpressure
        out_ready_i = 0; in_valid_i = 4'hF;
        in_data_i = 32'h01010101; tick();
        in_data_i = 32'h02020202; tick();
        in_data_i = 32'h03030303;
        #1 chk("full_ready_pre", in_ready_o, 4'hF);
        tick();
        chk("full_fill", lane_fill_o, 8'hFF);
        chk("full_ready", in_ready_o, 4'h0);
        in_data_i = 32'h04040404;
        tick();
        chk("full_beat4_drop", lane_fill_o, 8'hFF);
        in_valid_i = 0; out_ready_i = 4'h1;
        #1 chk("full_head", out_data_o, 32'h01010101);
        chk("full_ready_nothru", in_ready_o, 4'h0);
        tick();
        out_ready_i = 0;
        #1 chk("pop1_ready", in_ready_o, 4'h1);
        chk("pop1_fill", lane_fill_o, 8'hFE);
        chk("pop1_head", out_data_o, 32'h01010102);
        out_ready_i = 4'hF;
        tick(); tick(); tick();
        chk("full_drain_busy", busy_o, 0);

        // Simultaneous push/pop at fill=2 across pointer wrap
        out_ready_i = 0; in_valid_i = 4'hF;
        in_data_i = 32'h01010101; tick();
        in_data_i = 32'h02020202; tick();
        out_ready_i = 4'hF; in_data_i = 32'h03030303;
        #1 chk("pp_out1", out_data_o, 32'h01010101);
        tick();
        in_data_i = 32'h04040404;
        #1 chk("pp_fill1", lane_fill_o, 8'hAA);
        chk("pp_out2", out_data_o, 32'h02020202);
        tick();
        in_data_i = 32'h05050505;
        #1 chk("pp_fill2", lane_fill_o, 8'hAA);
        chk("pp_out3", out_data_o, 32'h03030303);
        tick();
        in_valid_i = 0;
        #1 chk("pp_out4", out_data_o, 32'h04040404);
        chk("pp_fill3", lane_fill_o, 8'hAA);
        tick();
        chk("pp_out5", out_data_o, 32'h05050505);
        chk("pp_fill4", lane_fill_o, 8'h55);
        tick();
        chk("pp_idle", busy_o, 0);

        // Flush mid-stream with concurrent valid input
        out_ready_i = 0; in_valid_i = 4'hF;
        in_data_i = 32'h11111111; tick();
        in_data_i = 32'h22222222; tick();
        flush_i = 1; in_data_i = 32'h99999999; out_ready_i = 4'hF;
        #1 chk("fl_ready", in_ready_o, 0);
        chk("fl_valid", out_valid_o, 0);
        tick();
        flush_i = 0; in_valid_i = 0;
        #1 chk("fl_fill", lane_fill_o, 0);
        chk("fl_busy", busy_o, 0);
        chk("fl_outvalid", out_valid_o, 0);
        in_data_i = 32'h12345678; in_valid_i = 4'hF;
        tick();
        in_valid_i = 0;
        #1 chk("fl_fresh", out_data_o, 32'h12345678);
        tick();
        chk("fl_idle", busy_o, 0);

        // Synchronous reset with full lanes
        out_ready_i = 0; in_valid_i = 4'hF;
        in_data_i = 32'hA1A1A1A1; tick();
        in_data_i = 32'hA2A2A2A2; tick();
        in_data_i = 32'hA3A3A3A3; tick();
        chk("rs_fill_pre", lane_fill_o, 8'hFF);
        rst_i = 1;
        #1 chk("rs_ready", in_ready_o, 0);
        chk("rs_valid", out_valid_o, 0);
        chk("rs_fill", lane_fill_o, 0);
        chk("rs_busy", busy_o, 0);
        tick();
        rst_i = 0; in_valid_i = 0;
        #1 chk("rs_ready_after", in_ready_o, 4'hF);
        chk("rs_busy_after", busy_o, 0);
        in_data_i = 32'hCAFEF00D; in_valid_i = 4'hF; out_ready_i = 4'hF;
        tick();
        in_valid_i = 0;
        #1 chk("rs_fresh_data", out_data_o, 32'hCAFEF00D);
        chk("rs_fresh_valid", out_valid_o, 4'hF);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
